// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Controller states:
    //   RUN     | normal hazard resolution, redirects taken directly
    //   DISCARD | stale fetch outstanding, waiting to drop it and load pend_target
    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          DEF_XLEN   = 32;
    localparam int          DEF_REG_AW = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage enables/flushes and perf counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_redirect;
    logic [XLEN-1:0]   ex_target;
    logic              imem_ready;
    logic              dmem_busy;
    logic              cnt_clr;

    logic              pc_en;
    logic              pc_sel_redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_en;
    logic              id_ex_flush;
    logic              ex_mem_en;
    logic              mem_wb_flush;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_events;

    // Pipeline side: reports hazards, consumes the control decisions.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_target, imem_ready, dmem_busy, cnt_clr,
        input  pc_en, pc_sel_redirect, redirect_pc, if_id_en, if_id_flush,
               id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush,
               stall_cycles, flush_events
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_target, imem_ready, dmem_busy, cnt_clr,
        output pc_en, pc_sel_redirect, redirect_pc, if_id_en, if_id_flush,
               id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/perf_counter_sat.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module perf_counter_sat #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, memory waits and EX redirects.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    state_e          state_q;
    state_e          state_d;
    logic [XLEN-1:0] pend_target;
    logic            load_use;

    logic            pc_en;
    logic            pc_sel_redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            if_id_en;
    logic            if_id_flush;
    logic            id_ex_en;
    logic            id_ex_flush;
    logic            ex_mem_en;
    logic            mem_wb_flush;
    logic            flush_inc;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != {REG_AW{1'b0}}) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the redirect target when the fetch it must replace is still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_target <= '0;
        end else if ((state_q == RUN) && !hz.dmem_busy && hz.ex_redirect && !hz.imem_ready) begin
            pend_target <= hz.ex_target;
        end
    end

    // Next-state: enter DISCARD on a redirect that cannot be taken yet, leave when the stale fetch lands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (!hz.dmem_busy && hz.ex_redirect && !hz.imem_ready) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (!hz.dmem_busy && hz.imem_ready) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Stage controls; a frozen MEM stage overrides everything since EX cannot move.
    always_comb begin
        pc_en           = 1'b1;
        pc_sel_redirect = 1'b0;
        redirect_pc     = hz.ex_target;
        if_id_en        = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_en        = 1'b1;
        id_ex_flush     = 1'b0;
        ex_mem_en       = 1'b1;
        mem_wb_flush    = 1'b0;
        flush_inc       = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.dmem_busy) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    mem_wb_flush = 1'b1;
                end else if (hz.ex_redirect) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_inc   = 1'b1;
                    if (hz.imem_ready) begin
                        pc_sel_redirect = 1'b1;
                    end else begin
                        pc_en = 1'b0;
                    end
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (!hz.imem_ready) begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                end
            end
            DISCARD: begin
                redirect_pc = pend_target;
                if (hz.dmem_busy) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_en    = 1'b0;
                    mem_wb_flush = 1'b1;
                end else begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (hz.imem_ready) begin
                        pc_sel_redirect = 1'b1;
                    end else begin
                        pc_en = 1'b0;
                    end
                end
            end
            default: begin
                pc_en = 1'b1;
            end
        endcase
    end

    assign hz.pc_en           = pc_en;
    assign hz.pc_sel_redirect = pc_sel_redirect;
    assign hz.redirect_pc     = redirect_pc;
    assign hz.if_id_en        = if_id_en;
    assign hz.if_id_flush     = if_id_flush;
    assign hz.id_ex_en        = id_ex_en;
    assign hz.id_ex_flush     = id_ex_flush;
    assign hz.ex_mem_en       = ex_mem_en;
    assign hz.mem_wb_flush    = mem_wb_flush;

    perf_counter_sat #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pc_en),
        .clr   (hz.cnt_clr),
        .count (hz.stall_cycles)
    );

    perf_counter_sat #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .clr   (hz.cnt_clr),
        .count (hz.flush_events)
    );

    // EX must hold a bubble while a stale fetch is being discarded.
    a_no_redirect_in_discard: assert property (
        @(posedge clk) disable iff (rst) (state_q == DISCARD) |-> !hz.ex_redirect
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    pipeline_hazard_ctrl_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    // Reference model: "waiting to discard a stale fetch" flag, the target to load, event counts.
    bit          m_wait;
    logic [31:0] m_pend;
    int          m_stall;
    int          m_flush;

    logic        e_pc_en, e_sel, e_if_en, e_if_fl, e_ie_en, e_ie_fl, e_em_en, e_mw_fl;
    logic [31:0] e_rpc;
    bit          e_flush_evt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_outputs();
        bit hazard;
        hazard = hz.ex_mem_read && (hz.ex_rd != 0) &&
                 ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
                  (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
        {e_pc_en, e_if_en, e_ie_en, e_em_en} = 4'b1111;
        {e_sel, e_if_fl, e_ie_fl, e_mw_fl}   = 4'b0000;
        e_flush_evt = 1'b0;
        e_rpc = m_wait ? m_pend : hz.ex_target;
        if (hz.dmem_busy) begin
            {e_pc_en, e_if_en, e_ie_en, e_em_en} = 4'b0000;
            e_mw_fl = 1'b1;
        end else if (m_wait || hz.ex_redirect) begin
            e_if_fl     = 1'b1;
            e_ie_fl     = 1'b1;
            e_sel       = hz.imem_ready;
            e_pc_en     = hz.imem_ready;
            e_flush_evt = !m_wait;
        end else if (hazard) begin
            e_pc_en = 1'b0;
            e_if_en = 1'b0;
            e_ie_fl = 1'b1;
        end else if (!hz.imem_ready) begin
            e_pc_en = 1'b0;
            e_if_fl = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        model_outputs();
        check({tag, ".pc_en"},    hz.pc_en,           e_pc_en);
        check({tag, ".pc_sel"},   hz.pc_sel_redirect, e_sel);
        check({tag, ".rpc"},      hz.redirect_pc,     e_rpc);
        check({tag, ".if_id_en"}, hz.if_id_en,        e_if_en);
        check({tag, ".if_id_fl"}, hz.if_id_flush,     e_if_fl);
        check({tag, ".id_ex_en"}, hz.id_ex_en,        e_ie_en);
        check({tag, ".id_ex_fl"}, hz.id_ex_flush,     e_ie_fl);
        check({tag, ".ex_mem_en"},hz.ex_mem_en,       e_em_en);
        check({tag, ".mem_wb_fl"},hz.mem_wb_flush,    e_mw_fl);
        check({tag, ".stall"},    hz.stall_cycles,    m_stall);
        check({tag, ".flush"},    hz.flush_events,    m_flush);
    endtask

    task automatic model_update();
        if (rst) begin
            m_wait = 0; m_pend = '0; m_stall = 0; m_flush = 0;
        end else begin
            if (hz.cnt_clr) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (!e_pc_en && m_stall < CMAX) m_stall++;
                if (e_flush_evt && m_flush < CMAX) m_flush++;
            end
            if (!hz.dmem_busy) begin
                if (!m_wait && hz.ex_redirect && !hz.imem_ready) begin
                    m_wait = 1; m_pend = hz.ex_target;
                end else if (m_wait && hz.imem_ready) begin
                    m_wait = 0;
                end
            end
        end
    endtask

    // Called just after a falling edge with inputs driven; ends at the next falling edge.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
        hz.ex_rd = '0; hz.ex_mem_read = 0; hz.ex_redirect = 0; hz.ex_target = '0;
        hz.imem_ready = 1; hz.dmem_busy = 0; hz.cnt_clr = 0;
    endtask

    task automatic clear_counters();
        idle_inputs();
        hz.cnt_clr = 1;
        cycle("clr");
        hz.cnt_clr = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        m_wait = 0; m_pend = '0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        #1;
        check_all("reset");
        check("reset.stall0", hz.stall_cycles, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Load-use: one bubble, then clear.
        hz.ex_mem_read = 1; hz.ex_rd = 5; hz.id_rs1 = 5; hz.id_use_rs1 = 1;
        #1;
        check("lu.pc_en", hz.pc_en, 1'b0);
        check("lu.if_id_en", hz.if_id_en, 1'b0);
        check("lu.id_ex_fl", hz.id_ex_flush, 1'b1);
        cycle("lu");
        hz.ex_mem_read = 0;
        #1;
        check("lu.stall1", hz.stall_cycles, 1);
        check("lu.after_pc_en", hz.pc_en, 1'b1);
        cycle("lu_after");
        hz.ex_mem_read = 1; hz.ex_rd = 0; hz.id_rs1 = 0;
        #1;
        check("lu_x0.pc_en", hz.pc_en, 1'b1);
        cycle("lu_x0");

        // Redirect with fetch ready.
        idle_inputs();
        hz.ex_redirect = 1; hz.ex_target = 32'h0000_0100;
        #1;
        check("rd.pc_sel", hz.pc_sel_redirect, 1'b1);
        check("rd.rpc", hz.redirect_pc, 32'h100);
        cycle("rd");
        hz.ex_redirect = 0;
        #1;
        check("rd.flush1", hz.flush_events, 1);

        // Redirect while the fetch is still outstanding.
        clear_counters();
        hz.ex_redirect = 1; hz.ex_target = 32'h0000_0200; hz.imem_ready = 0;
        cycle("rdw0");
        hz.ex_redirect = 0; hz.ex_target = 32'h0000_0bad;
        cycle("rdw1");
        #1;
        check("rdw.if_id_fl", hz.if_id_flush, 1'b1);
        cycle("rdw2");
        hz.imem_ready = 1;
        #1;
        check("rdw.pc_sel", hz.pc_sel_redirect, 1'b1);
        check("rdw.rpc", hz.redirect_pc, 32'h200);
        cycle("rdw3");
        #1;
        check("rdw.stall3", hz.stall_cycles, 3);
        check("rdw.back_run", hz.pc_sel_redirect, 1'b0);
        cycle("rdw4");

        // dmem_busy freezes over a concurrent load-use and redirect.
        clear_counters();
        hz.dmem_busy = 1; hz.ex_mem_read = 1; hz.ex_rd = 7; hz.id_rs2 = 7; hz.id_use_rs2 = 1;
        hz.ex_redirect = 1; hz.ex_target = 32'h0000_0300;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("busy.mem_wb_fl", hz.mem_wb_flush, 1'b1);
            check("busy.ex_mem_en", hz.ex_mem_en, 1'b0);
            cycle("busy");
        end
        hz.dmem_busy = 0;
        #1;
        check("busy.rd_sel", hz.pc_sel_redirect, 1'b1);
        check("busy.rd_rpc", hz.redirect_pc, 32'h300);
        cycle("busy_rd");
        idle_inputs();
        #1;
        check("busy.flush1", hz.flush_events, 1);

        // Counter saturation and clear-over-increment.
        clear_counters();
        hz.imem_ready = 0;
        for (int i = 0; i < 20; i++) cycle("sat");
        #1;
        check("sat.stall15", hz.stall_cycles, 15);
        hz.cnt_clr = 1;
        cycle("sat_clr");
        hz.cnt_clr = 0;
        #1;
        check("sat.clr0", hz.stall_cycles, 0);

        // Asynchronous reset in the middle of DISCARD.
        idle_inputs();
        hz.ex_redirect = 1; hz.ex_target = 32'h0000_0400; hz.imem_ready = 0;
        cycle("rst0");
        hz.ex_redirect = 0;
        cycle("rst1");
        #2;
        rst = 1'b1;
        m_wait = 0; m_pend = '0; m_stall = 0; m_flush = 0;
        #1;
        check("rst.stall0", hz.stall_cycles, 0);
        check("rst.flush0", hz.flush_events, 0);
        hz.imem_ready = 1;
        #1;
        check_all("rst_mid");
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.no_redirect", hz.pc_sel_redirect, 1'b0);
        cycle("rst_rel");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            hz.id_rs1      = 5'($urandom_range(0, 3));
            hz.id_rs2      = 5'($urandom_range(0, 3));
            hz.id_use_rs1  = 1'($urandom_range(0, 1));
            hz.id_use_rs2  = 1'($urandom_range(0, 1));
            hz.ex_rd       = 5'($urandom_range(0, 3));
            hz.ex_mem_read = ($urandom_range(0, 2) == 0);
            hz.ex_redirect = !m_wait && ($urandom_range(0, 5) == 0);
            hz.ex_target   = $urandom & 32'hffff_fffc;
            hz.imem_ready  = ($urandom_range(0, 2) != 0);
            hz.dmem_busy   = ($urandom_range(0, 4) == 0);
            hz.cnt_clr     = ($urandom_range(0, 29) == 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
